pe_result_writeback: RTL and testbench

Downstream stage of a PE pair: absorbs the per-PE result tiles (6x6 signed 12-bit, address, one-cycle valid pulse), buffers each stream in a small FIFO and round-robin arbitrates them onto the single write port of one output_mem_top instance. Two instances are used: one for PE0/PE1 into output memory 0, one for PE2/PE3 into output memory 1. PEs have no backpressure, so this block exists to absorb bursts, serialise writes and flag any loss.

---
 rtl/pe_result_writeback.sv | 117 +++++++++++
 tb/tb_pe_result_writeback.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_writeback.sv
// Buffers result tiles from two PEs in per-PE FIFOs and round-robin serialises
// them onto a single output-memory write port, flagging any dropped push.
module pe_result_writeback #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [5:0][5:0][11:0]  pe_a_tile_i,
  input  logic [ADDR_W-1:0]             pe_a_addr_i,
  input  logic                          pe_a_valid_i,
  input  logic signed [5:0][5:0][11:0]  pe_b_tile_i,
  input  logic [ADDR_W-1:0]             pe_b_addr_i,
  input  logic                          pe_b_valid_i,
  input  logic                          mem_ready_i,
  output logic                          mem_wen_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [511:0]                  mem_data_o,
  output logic [15:0]                   write_count_o,
  output logic                          overflow_o,
  output logic                          idle_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TILE_W = 432;
  localparam int unsigned ENT_W  = ADDR_W + TILE_W;

  typedef enum logic {GRANT_A, GRANT_B} grant_e;

  grant_e            last_grant;
  logic [ENT_W-1:0]  fifo_mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [CNT_W-1:0]  occ [2];
  logic [ENT_W-1:0]  in_ent [2];
  logic [ENT_W-1:0]  head;
  logic [1:0]        valid, empty, full, push, pop, drop;

  // Packed tile [r][c] already sits at bit (r*6+c)*12, so the flat vector is the memory layout.
  assign in_ent[0] = {pe_a_addr_i, pe_a_tile_i};
  assign in_ent[1] = {pe_b_addr_i, pe_b_tile_i};
  assign valid     = {pe_b_valid_i, pe_a_valid_i};

  always_comb begin
    empty = '0;
    full  = '0;
    pop   = '0;
    push  = '0;
    drop  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      empty[i] = (occ[i] == '0);
      full[i]  = (occ[i] == CNT_W'(FIFO_DEPTH));
    end
    if (mem_ready_i) begin
      if (!empty[0] && !empty[1]) begin
        if (last_grant == GRANT_B) pop[0] = 1'b1;
        else                       pop[1] = 1'b1;
      end else if (!empty[0]) begin
        pop[0] = 1'b1;
      end else if (!empty[1]) begin
        pop[1] = 1'b1;
      end
    end
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    for (int unsigned i = 0; i < 2; i++) begin
      push[i] = valid[i] && (!full[i] || pop[i]);
      drop[i] = valid[i] && full[i] && !pop[i];
    end
    head = pop[0] ? fifo_mem[0][rd_ptr[0]] : fifo_mem[1][rd_ptr[1]];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) fifo_mem[i][wr_ptr[i]] <= in_ent[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        occ[i]    <= '0;
      end
      last_grant    <= GRANT_B;
      mem_wen_o     <= 1'b0;
      mem_addr_o    <= '0;
      mem_data_o    <= '0;
      write_count_o <= '0;
      overflow_o    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        unique case ({push[i], pop[i]})
          2'b10:   occ[i] <= occ[i] + 1'b1;
          2'b01:   occ[i] <= occ[i] - 1'b1;
          default: occ[i] <= occ[i];
        endcase
      end
      mem_wen_o <= |pop;
      if (|pop) begin
        mem_addr_o    <= head[ENT_W-1 -: ADDR_W];
        mem_data_o    <= {{(512-TILE_W){1'b0}}, head[TILE_W-1:0]};
        write_count_o <= write_count_o + 16'd1;
        last_grant    <= pop[0] ? GRANT_A : GRANT_B;
      end
      if (|drop) overflow_o <= 1'b1;
    end
  end

  assign idle_o = empty[0] && empty[1] && !mem_wen_o;

endmodule

// File: tb/tb_pe_result_writeback.sv
// Bench for pe_result_writeback: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pe_result_writeback;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [5:0][5:0][11:0] a_tile = '0, b_tile = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic mem_ready = 1'b1;
  logic mem_wen;
  logic [AW-1:0] mem_addr;
  logic [511:0] mem_data;
  logic [15:0] write_count;
  logic overflow, idle;

  always #5 clk = ~clk;

  pe_result_writeback #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .pe_a_tile_i(a_tile), .pe_a_addr_i(a_addr), .pe_a_valid_i(a_valid),
    .pe_b_tile_i(b_tile), .pe_b_addr_i(b_addr), .pe_b_valid_i(b_valid),
    .mem_ready_i(mem_ready), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .write_count_o(write_count),
    .overflow_o(overflow), .idle_o(idle)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] pack(input logic [5:0][5:0][11:0] t);
    logic [511:0] p;
    p = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        p[(r*6+c)*12 +: 12] = t[r][c];
    return p;
  endfunction

  // Reference model: two bounded queues, round-robin preference, registered write.
  typedef struct { logic [AW-1:0] a; logic [511:0] d; } ent_t;
  ent_t qa[$], qb[$];
  ent_t e;
  bit last_b, model_live, pa, pb;
  logic m_wen, m_ovf;
  logic [AW-1:0] m_addr;
  logic [511:0] m_data;
  logic [15:0] m_cnt;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      qa.delete(); qb.delete();
      last_b = 1; m_wen = 0; m_addr = '0; m_data = '0; m_cnt = '0; m_ovf = 0;
      model_live = 1;
    end else begin
      pa = 0; pb = 0;
      if (mem_ready) begin
        if (qa.size() > 0 && (qb.size() == 0 || last_b)) pa = 1;
        else if (qb.size() > 0) pb = 1;
      end
      m_wen = pa | pb;
      if (pa) begin e = qa.pop_front(); last_b = 0; end
      if (pb) begin e = qb.pop_front(); last_b = 1; end
      if (m_wen) begin m_addr = e.a; m_data = e.d; m_cnt = m_cnt + 16'd1; end
      if (a_valid) begin
        if (qa.size() < DEPTH) qa.push_back('{a_addr, pack(a_tile)}); else m_ovf = 1;
      end
      if (b_valid) begin
        if (qb.size() < DEPTH) qb.push_back('{b_addr, pack(b_tile)}); else m_ovf = 1;
      end
    end
  end

  logic [AW-1:0] wr_log[$];
  int wr_cyc[$];

  initial forever begin
    @(negedge clk);
    if (model_live) begin
      chk("wen", mem_wen, m_wen);
      chk("addr", mem_addr, m_addr);
      chk("data", mem_data, m_data);
      chk("count", write_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("idle", idle, qa.size() == 0 && qb.size() == 0 && !m_wen);
      if (mem_wen) begin wr_log.push_back(mem_addr); wr_cyc.push_back(cyc); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; a_valid = 0; b_valid = 0; mem_ready = 1;
    tick(2);
    reset = 0;
  endtask

  logic [15:0] exp_addr;

  initial begin
    tick(1);
    do_reset();

    // Single push with a ramp tile
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) a_tile[r][c] = 12'(r*6+c);
    a_addr = 12'h012; a_valid = 1;
    tick(1); a_valid = 0;
    tick(1);
    chk("t1_wen", mem_wen, 1'b1);
    chk("t1_addr", mem_addr, 12'h012);
    chk("t1_lsb_field", mem_data[11:0], 12'd0);
    chk("t1_last_field", mem_data[431:420], 12'd35);
    chk("t1_pad", mem_data[511:432], 80'd0);
    chk("t1_count", write_count, 16'd1);
    tick(3);

    // Both PEs every cycle for 4 cycles
    do_reset();
    wr_log.delete(); wr_cyc.delete();
    a_addr = 12'd1; b_addr = 12'd2; b_tile = a_tile;
    a_valid = 1; b_valid = 1;
    tick(4); a_valid = 0; b_valid = 0;
    tick(12);
    chk("t2_nwrites", wr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++)
      chk("t2_order", wr_log[i], (i % 2 == 0) ? 12'd1 : 12'd2);
    if (wr_cyc.size() == 8) chk("t2_span", wr_cyc[7] - wr_cyc[0], 7);
    chk("t2_ovf", overflow, 1'b0);
    chk("t2_idle", idle, 1'b1);

    // Overflow with memory stalled
    do_reset();
    mem_ready = 0; wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      a_addr = 12'(10 + i); a_valid = 1; tick(1);
    end
    a_valid = 0; tick(1);
    chk("t3_ovf_set", overflow, 1'b1);
    chk("t3_no_write", wr_log.size(), 0);
    mem_ready = 1; tick(8);
    chk("t3_nwrites", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      exp_addr = 16'(10 + i);
      chk("t3_order", wr_log[i], exp_addr[AW-1:0]);
    end
    chk("t3_ovf_sticky", overflow, 1'b1);

    // Push into a full FIFO on its pop cycle
    do_reset();
    mem_ready = 0; wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      a_addr = 12'(20 + i); a_valid = 1; tick(1);
    end
    mem_ready = 1;
    for (int i = 4; i < 7; i++) begin
      a_addr = 12'(20 + i); a_valid = 1; tick(1);
    end
    a_valid = 0; tick(8);
    chk("t4_ovf", overflow, 1'b0);
    chk("t4_nwrites", wr_log.size(), 7);
    for (int i = 0; i < 7 && i < wr_log.size(); i++) begin
      exp_addr = 16'(20 + i);
      chk("t4_order", wr_log[i], exp_addr[AW-1:0]);
    end
    chk("t4_idle", idle, 1'b1);

    // Most negative values and write counter wrap
    do_reset();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) a_tile[r][c] = -12'sd2048;
    for (int i = 0; i < 65535; i++) begin
      a_addr = 12'(i); a_valid = 1; tick(1);
    end
    a_valid = 0; tick(4);
    chk("t5_count_max", write_count, 16'hFFFF);
    for (int f = 0; f < 36; f++) chk("t5_field", mem_data[f*12 +: 12], 12'h800);
    chk("t5_pad", mem_data[511:432], 80'd0);
    a_addr = 12'h7AB; a_valid = 1; tick(1);
    a_valid = 0; tick(1);
    chk("t5_wrap_wen", mem_wen, 1'b1);
    chk("t5_wrap_count", write_count, 16'h0000);
    chk("t5_wrap_addr", mem_addr, 12'h7AB);

    // Reset with entries queued
    do_reset();
    a_addr = 12'd40; a_valid = 1; tick(1);
    a_valid = 0; tick(3);
    chk("t6_pre_count", write_count, 16'd1);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_addr = 12'(50 + i); a_valid = 1; tick(1);
    end
    reset = 1; mem_ready = 1; a_valid = 1; b_valid = 1; a_addr = 12'd60; b_addr = 12'd61;
    tick(1);
    chk("t6_wen", mem_wen, 1'b0);
    chk("t6_count", write_count, 16'd0);
    chk("t6_addr", mem_addr, 12'd0);
    chk("t6_idle", idle, 1'b1);
    reset = 0; a_valid = 0; b_valid = 0; wr_log.delete();
    tick(6);
    chk("t6_no_writes", wr_log.size(), 0);
    chk("t6_idle_after", idle, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
